// File: rtl/proc_gen_pkg.sv
// proc_gen_pkg: opcodes, FSM states and bus-select encoding shared by the processor files
package proc_gen_pkg;
  typedef enum logic [2:0] {
    OP_MV   = 3'b000,
    OP_MVI  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_AND  = 3'b100,
    OP_OR   = 3'b101,
    OP_MVNZ = 3'b110,
    OP_NOP  = 3'b111
  } opcode_e;
  typedef enum logic [1:0] {T0, T1, T2, T3} state_e;
  typedef enum logic [1:0] {SEL_ZERO, SEL_DIN, SEL_REG, SEL_G} bus_sel_e;
endpackage

// File: rtl/proc_gen_if.sv
// proc_gen_if: instruction/operand inputs and bus/status outputs of the processor
interface proc_gen_if #(parameter int N = 16) ();
  logic [N-1:0] DIN;
  logic         Run;
  logic         Done;
  logic [N-1:0] BusWires;
  logic         Zero;
  logic         Carry;
  modport master (output DIN, Run, input Done, BusWires, Zero, Carry);
  modport slave  (input DIN, Run, output Done, BusWires, Zero, Carry);
endinterface

// File: rtl/proc_gen_alu.sv
// proc_gen_alu: combinational ADD/SUB/AND/OR with carry/borrow and zero detect
module proc_gen_alu
  import proc_gen_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  opcode_e      i_op,
  output logic [N-1:0] o_result,
  output logic         o_carry,
  output logic         o_zero
);
  logic [N:0] w_sum, w_diff;
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  // the extra bit of an unsigned subtract is set exactly when a borrow occurs
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};
  always_comb begin
    o_result = i_op == OP_ADD ? w_sum[N-1:0] :
               i_op == OP_SUB ? w_diff[N-1:0] :
               i_op == OP_AND ? (i_a & i_b) : (i_a | i_b);
    o_carry  = i_op == OP_ADD ? w_sum[N] : i_op == OP_SUB ? w_diff[N] : 1'b0;
    o_zero   = o_result == '0;
  end
endmodule

// File: rtl/proc_gen.sv
// proc_gen: multicycle bus-based processor with register file, ALU and T0..T3 control FSM
module proc_gen
  import proc_gen_pkg::*;
#(
  parameter int N  = 16,
  parameter int RW = 3
) (
  input  logic        Clock,
  input  logic        Resetn,
  proc_gen_if.slave   bus
);
  localparam int IW = 3 + 2 * RW;
  localparam int NR = 1 << RW;
  state_e        r_state, w_next;
  logic [IW-1:0] r_ir;
  logic [N-1:0]  r_regs [NR];
  logic [N-1:0]  r_a, r_g;
  logic          r_zero, r_carry;
  opcode_e       w_op;
  logic [RW-1:0] w_rx, w_ry, w_ri;
  bus_sel_e      w_sel;
  logic          w_we, w_a_ld, w_g_ld, w_ir_ld, w_done;
  logic [N-1:0]  w_bus, w_res;
  logic          w_c, w_z;
  assign w_op = opcode_e'(r_ir[IW-1 -: 3]);
  assign w_rx = r_ir[2*RW-1 -: RW];
  assign w_ry = r_ir[RW-1:0];
  always_ff @(posedge Clock) r_state <= !Resetn ? T0 : w_next;
  // outputs are suppressed while Resetn is low so an aborted instruction never pulses Done
  always_comb begin
    w_next  = r_state;
    w_sel   = SEL_ZERO;
    w_ri    = w_ry;
    w_we    = 1'b0;
    w_a_ld  = 1'b0;
    w_g_ld  = 1'b0;
    w_ir_ld = 1'b0;
    w_done  = 1'b0;
    if (Resetn) begin
      case (r_state)
        T0: begin
          w_ir_ld = bus.Run;
          w_next  = bus.Run ? T1 : T0;
        end
        T1: begin
          w_next = T0;
          case (w_op)
            OP_MV:   begin w_sel = SEL_REG; w_we = 1'b1; w_done = 1'b1; end
            OP_MVI:  begin w_sel = SEL_DIN; w_we = 1'b1; w_done = 1'b1; end
            OP_MVNZ: begin w_sel = SEL_REG; w_we = !r_zero; w_done = 1'b1; end
            OP_NOP:  w_done = 1'b1;
            default: begin w_sel = SEL_REG; w_ri = w_rx; w_a_ld = 1'b1; w_next = T2; end
          endcase
        end
        T2: begin
          w_sel  = SEL_REG;
          w_g_ld = 1'b1;
          w_next = T3;
        end
        T3: begin
          w_sel  = SEL_G;
          w_we   = 1'b1;
          w_done = 1'b1;
          w_next = T0;
        end
        default: w_next = T0;
      endcase
    end
  end
  assign w_bus = w_sel == SEL_DIN ? bus.DIN :
                 w_sel == SEL_REG ? r_regs[w_ri] :
                 w_sel == SEL_G   ? r_g : '0;
  proc_gen_alu #(.N(N)) u_alu (
    .i_a      (r_a),
    .i_b      (w_bus),
    .i_op     (w_op),
    .o_result (w_res),
    .o_carry  (w_c),
    .o_zero   (w_z)
  );
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      for (int i = 0; i < NR; i++) r_regs[i] <= '0;
      r_ir    <= '0;
      r_a     <= '0;
      r_g     <= '0;
      r_zero  <= 1'b1;
      r_carry <= 1'b0;
    end else begin
      if (w_ir_ld) r_ir <= bus.DIN[IW-1:0];
      if (w_a_ld) r_a <= w_bus;
      if (w_g_ld) begin
        r_g     <= w_res;
        r_zero  <= w_z;
        r_carry <= w_c;
      end
      if (w_we) r_regs[w_rx] <= w_bus;
    end
  end
  assign bus.Done     = w_done;
  assign bus.BusWires = w_bus;
  assign bus.Zero     = r_zero;
  assign bus.Carry    = r_carry;
endmodule

// File: tb/tb_proc_gen.sv
// tb_proc_gen: directed checks of proc_gen timing, bus values, flags and reset abort
module tb_proc_gen;
  logic clk = 1'b0;
  logic resetn;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [15:0] t1;
  proc_gen_if #(.N(16)) pif ();
  proc_gen #(.N(16), .RW(3)) dut (
    .Clock  (clk),
    .Resetn (resetn),
    .bus    (pif.slave)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [15:0] ins(input logic [2:0] op, input logic [2:0] x, input logic [2:0] y);
    return {7'b1010000, op, x, y};
  endfunction
  // fetch at T0 (cycle 1), then count cycles until Done; t1bus captures BusWires in T1
  task automatic exec(input logic [15:0] i, input logic [15:0] imm, input int lat,
                      input string tag, output logic [15:0] t1bus);
    int c;
    pif.DIN = i;
    pif.Run = 1'b1;
    tick();
    pif.Run = 1'b0;
    pif.DIN = imm;
    #1;
    t1bus = pif.BusWires;
    c = 2;
    while (c < 10 && !pif.Done) begin
      tick();
      c++;
    end
    chk({tag, " latency"}, c, lat);
    tick();
    chk({tag, " done one cycle"}, {31'b0, pif.Done}, 0);
    pif.DIN = 16'h0;
  endtask
  task automatic rd(input logic [2:0] r, input logic [15:0] exp, input string tag);
    logic [15:0] b;
    exec(ins(3'b000, r, r), 16'h0, 2, {tag, " rd"}, b);
    chk(tag, b, exp);
  endtask
  task automatic mvi(input logic [2:0] r, input logic [15:0] v);
    logic [15:0] b;
    exec(ins(3'b001, r, 3'd0), v, 2, "mvi", b);
  endtask
  initial begin
    resetn = 1'b0;
    pif.Run = 1'b1;
    pif.DIN = ins(3'b001, 3'd0, 3'd0);
    tick();
    tick();
    chk("reset done", {31'b0, pif.Done}, 0);
    chk("reset bus", pif.BusWires, 0);
    chk("reset zero", {31'b0, pif.Zero}, 1);
    chk("reset carry", {31'b0, pif.Carry}, 0);
    resetn = 1'b1;
    pif.Run = 1'b0;
    tick();
    chk("idle done", {31'b0, pif.Done}, 0);
    exec(ins(3'b001, 3'd0, 3'd0), 16'h1234, 2, "mvi r0", t1);
    chk("mvi r0 t1 bus", t1, 16'h1234);
    rd(3'd0, 16'h1234, "r0");
    mvi(3'd1, 16'hFFFF);
    mvi(3'd2, 16'h0001);
    exec(ins(3'b010, 3'd1, 3'd2), 16'h0, 4, "add r1 r2", t1);
    chk("add t1 bus rx", t1, 16'hFFFF);
    chk("add zero", {31'b0, pif.Zero}, 1);
    chk("add carry", {31'b0, pif.Carry}, 1);
    rd(3'd1, 16'h0000, "r1 after add");
    mvi(3'd3, 16'h0005);
    mvi(3'd4, 16'h0007);
    exec(ins(3'b011, 3'd3, 3'd4), 16'h0, 4, "sub r3 r4", t1);
    chk("sub carry", {31'b0, pif.Carry}, 1);
    chk("sub zero", {31'b0, pif.Zero}, 0);
    rd(3'd3, 16'hFFFE, "r3 after sub");
    exec(ins(3'b110, 3'd5, 3'd3), 16'h0, 2, "mvnz r5 r3", t1);
    rd(3'd5, 16'hFFFE, "r5 after mvnz");
    mvi(3'd0, 16'h00AA);
    mvi(3'd7, 16'h0777);
    mvi(3'd6, 16'h0042);
    exec(ins(3'b011, 3'd6, 3'd6), 16'h0, 4, "sub r6 r6", t1);
    chk("sub self zero", {31'b0, pif.Zero}, 1);
    chk("sub self carry", {31'b0, pif.Carry}, 0);
    rd(3'd6, 16'h0000, "r6 after sub self");
    exec(ins(3'b110, 3'd7, 3'd0), 16'h0, 2, "mvnz blocked", t1);
    rd(3'd7, 16'h0777, "r7 unchanged");
    mvi(3'd3, 16'h4321);
    exec(ins(3'b010, 3'd3, 3'd3), 16'h0, 4, "add r3 r3", t1);
    rd(3'd3, 16'h8642, "r3 doubled");
    exec(ins(3'b111, 3'd0, 3'd0), 16'h0, 2, "nop", t1);
    chk("nop t1 bus", t1, 16'h0);
    mvi(3'd1, 16'h0010);
    pif.DIN = ins(3'b010, 3'd1, 3'd2);
    pif.Run = 1'b1;
    tick();
    pif.Run = 1'b0;
    chk("abort t1 done", {31'b0, pif.Done}, 0);
    tick();
    resetn = 1'b0;
    #1;
    chk("abort t2 done", {31'b0, pif.Done}, 0);
    chk("abort t2 bus", pif.BusWires, 0);
    tick();
    resetn = 1'b1;
    #1;
    chk("abort after done", {31'b0, pif.Done}, 0);
    chk("abort after bus", pif.BusWires, 0);
    tick();
    chk("abort no late done", {31'b0, pif.Done}, 0);
    rd(3'd1, 16'h0000, "r1 after abort");
    rd(3'd2, 16'h0000, "r2 after abort");
    mvi(3'd1, 16'h00F0);
    mvi(3'd2, 16'h0F3C);
    pif.DIN = ins(3'b000, 3'd3, 3'd1);
    pif.Run = 1'b1;
    tick();
    chk("b2b c2 done", {31'b0, pif.Done}, 1);
    chk("b2b c2 bus", pif.BusWires, 16'h00F0);
    pif.DIN = ins(3'b100, 3'd2, 3'd1);
    tick();
    chk("b2b c3 done", {31'b0, pif.Done}, 0);
    chk("b2b c3 bus", pif.BusWires, 0);
    tick();
    chk("b2b c4 bus", pif.BusWires, 16'h0F3C);
    tick();
    chk("b2b c5 bus", pif.BusWires, 16'h00F0);
    chk("b2b c5 done", {31'b0, pif.Done}, 0);
    tick();
    chk("b2b c6 done", {31'b0, pif.Done}, 1);
    chk("b2b c6 bus", pif.BusWires, 16'h0030);
    pif.DIN = ins(3'b111, 3'd0, 3'd0);
    tick();
    chk("b2b c7 done", {31'b0, pif.Done}, 0);
    tick();
    chk("b2b c8 done", {31'b0, pif.Done}, 1);
    chk("b2b c8 bus", pif.BusWires, 0);
    pif.Run = 1'b0;
    tick();
    chk("b2b c9 done", {31'b0, pif.Done}, 0);
    chk("and zero", {31'b0, pif.Zero}, 0);
    chk("and carry", {31'b0, pif.Carry}, 0);
    rd(3'd2, 16'h0030, "r2 after and");
    rd(3'd3, 16'h00F0, "r3 after mv");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/proc_gen.md
PROC_GEN -- requirements
Module: proc_gen

Interface
REQ-001 Parameter N, default 16: data/bus width; legal range 9..32.
REQ-002 Parameter RW, default 3: register-address field width; register file holds 2**RW registers; legal when 3+2*RW <= N.
REQ-003 Clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Resetn  input  1  reset; one clock, reset synchronous and active-low.
REQ-005 DIN  input  N  instruction word in fetch cycle; immediate operand in MVI execute cycle.
REQ-006 Run  input  1  start request, sampled only in state T0.
REQ-007 Done  output  1  high during the final execute cycle of every instruction.
REQ-008 BusWires  output  N  current internal bus value.
REQ-009 Zero  output  1  registered flag: G == 0 after last ALU op.
REQ-010 Carry  output  1  registered flag: carry-out (ADD) or borrow (SUB) of last arithmetic op.

Function
REQ-011 Instruction = DIN[3+2*RW-1:0], fields III | X (RW bits) | Y (RW bits), opcode in MSBs; DIN upper bits ignored at fetch.
REQ-012 Opcodes: 000 MV, 001 MVI, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 MVNZ, 111 NOP.
REQ-013 States T0 (idle/fetch), T1, T2, T3; T0 -> T1 on Run=1 with IR <= instruction; T0 holds while Run=0.
REQ-014 MV: T1 bus = Ry, Rx <= bus, Done=1, -> T0; latency 2 cycles from Run sample.
REQ-015 MVI: T1 bus = DIN (full N bits), Rx <= bus, Done=1, -> T0.
REQ-016 MVNZ: T1 bus = Ry; Rx <= bus only if Zero=0; Done=1 regardless; -> T0.
REQ-017 NOP: T1 Done=1, no register write, -> T0.
REQ-018 ADD/SUB/AND/OR: T1 bus = Rx, A <= bus; T2 bus = Ry, G <= A op bus, flags updated; T3 bus = G, Rx <= bus, Done=1, -> T0; latency 4 cycles.
REQ-019 Arithmetic modulo 2**N; Carry = bit N of A+Ry (ADD), = 1 when A < Ry unsigned (SUB); AND/OR clear Carry.
REQ-020 Zero and Carry change only at end of T2 of ALU ops.
REQ-021 Run ignored outside T0; DIN ignored except at T0 fetch and MVI T1.
REQ-022 X == Y legal: ADD R3,R3 doubles R3; SUB R3,R3 yields 0, Zero=1, Carry=0.
REQ-023 Bus value is 0 in T0 and in T1 of NOP; exactly one source drives per cycle.
REQ-024 At most one register write per cycle; Done high for exactly one cycle per instruction.
REQ-025 Back-to-back: Run held high fetches a new instruction in the T0 cycle immediately following Done.

Reset
REQ-026 Resetn=0 at a rising edge: state <= T0; all registers, A, G, IR <= 0; Zero <= 1; Carry <= 0.
REQ-027 During/after reset cycle Done=0, BusWires=0.
REQ-028 Reset mid-instruction aborts it: no Rx write, no Done pulse; Run sampled again from the first T0 cycle after Resetn=1.

Structure
REQ-029 Package proc_gen_pkg holds opcode constants, state encoding T0..T3, and bus-select encoding.
REQ-030 Sub-module proc_gen_alu (combinational, parameter N): inputs A, B, opcode; outputs result, carry, zero.
REQ-031 Register file, bus multiplexer, and FSM reside in proc_gen; no other sub-modules.

Verification (N=16, RW=3)
REQ-032 Reset, then MVI R0 with DIN=0x1234 at T1 -> R0=0x1234, Done at cycle 2, BusWires=0x1234 in T1.
REQ-033 R1=0xFFFF, R2=0x0001, ADD R1,R2 -> R1=0x0000, Zero=1, Carry=1, Done exactly at cycle 4.
REQ-034 R3=0x0005, R4=0x0007, SUB R3,R4 -> R3=0xFFFE, Carry=1, Zero=0; then MVNZ R5,R3 -> R5=0xFFFE.
REQ-035 After SUB R6,R6 (Zero=1), MVNZ R7,R0 with R0=0x00AA -> R7 unchanged, Done still pulses.
REQ-036 Resetn=0 during T2 of ADD R1,R2 -> R1=0 after reset, no Done pulse, next Run fetches normally.
REQ-037 Run held high over MV, AND, NOP sequence -> back-to-back execution, Done pulses at cycles 2, 6, 8.
